// File: rtl/osd_pkg.sv
// Shared OSD definitions: write-port FSM states, ASCII codes and screen geometry.
package osd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } osd_wr_state_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   localparam int unsigned OSD_COLS          = 48;
   localparam int unsigned OSD_ROWS          = 32;
   localparam int unsigned OSD_CHAR_RAM_SIZE = OSD_COLS * OSD_ROWS;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Round-robin grant generator: picks the first request at or after ptr, wrapping.
module osd_rr_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned SW = IW + 1;

   logic [NUM_REQ-1:0] rot;
   logic [IW-1:0]      offset;
   logic               any;
   logic [SW-1:0]      sum;

   // Rotate so ptr sits at bit 0, find the lowest set bit, then map back with wrap.
   always_comb begin
      rot    = NUM_REQ'({req, req} >> ptr);
      offset = '0;
      any    = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            offset = IW'(k);
            any    = 1'b1;
         end
      end
      sum = SW'(ptr) + SW'(offset);
      if (sum >= SW'(NUM_REQ)) begin
         sum = sum - SW'(NUM_REQ);
      end
      idx   = sum[IW-1:0];
      grant = any ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/osd_char_wr_arbiter.sv
// Character RAM write-port scheduler: round-robin requesters plus full-screen clear.
module osd_char_wr_arbiter
   import osd_pkg::*;
#(
   parameter int unsigned           NUM_REQ       = 3,
   parameter int unsigned           ADDR_WIDTH    = 11,
   parameter int unsigned           DATA_WIDTH    = 8,
   parameter int unsigned           CHAR_RAM_SIZE = OSD_CHAR_RAM_SIZE,
   parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR    = DATA_WIDTH'(ASCII_SPACE)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          clear_start,
   output logic                          clear_busy,
   output logic                          wr_en,
   output logic [ADDR_WIDTH-1:0]         wr_addr,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          oob_drop
);

   localparam int unsigned IDX_WIDTH = $clog2(NUM_REQ);

   osd_wr_state_t          state, state_nxt;
   logic [IDX_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
   logic [ADDR_WIDTH-1:0]  clr_addr, clr_addr_nxt;
   logic                   wr_en_nxt, oob_drop_nxt;
   logic [ADDR_WIDTH-1:0]  wr_addr_nxt;
   logic [DATA_WIDTH-1:0]  wr_data_nxt;
   logic [IDX_WIDTH-1:0]   grant_id_nxt;

   logic [NUM_REQ-1:0]     arb_req;
   logic [NUM_REQ-1:0]     arb_grant;
   logic [IDX_WIDTH-1:0]   arb_idx;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_data;

   // Requests only compete in IDLE when no clear is being launched.
   always_comb begin
      arb_req = '0;
      if (!reset && state == IDLE && !clear_start) begin
         arb_req = req_valid;
      end
   end

   osd_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req   (arb_req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   assign req_ready = arb_grant;

   // Mux the granted requester's payload.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state and next-output logic for the arbitrate/clear FSM.
   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      clr_addr_nxt = clr_addr;
      wr_en_nxt    = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      grant_id_nxt = grant_id;
      oob_drop_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_start) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end else if (|arb_grant) begin
               rr_ptr_nxt = (arb_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_WIDTH'(1);
               if (32'(sel_addr) < CHAR_RAM_SIZE) begin
                  wr_en_nxt    = 1'b1;
                  wr_addr_nxt  = sel_addr;
                  wr_data_nxt  = sel_data;
                  grant_id_nxt = arb_idx;
               end else begin
                  oob_drop_nxt = 1'b1;
               end
            end
         end
         CLEAR: begin
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = clr_addr;
            wr_data_nxt  = CLEAR_CHAR;
            clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
            if (clr_addr == ADDR_WIDTH'(CHAR_RAM_SIZE - 1)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, pointer, clear counter and registered write-port outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         clr_addr   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         grant_id   <= '0;
         oob_drop   <= 1'b0;
         clear_busy <= 1'b0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         clr_addr   <= clr_addr_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         grant_id   <= grant_id_nxt;
         oob_drop   <= oob_drop_nxt;
         clear_busy <= (state_nxt == CLEAR);
      end
   end

endmodule

// File: tb/tb_osd_char_wr_arbiter.sv
// Randomized bench for osd_char_wr_arbiter with a behavioural write-port model.
module tb_osd_char_wr_arbiter;

   localparam int unsigned N    = 3;
   localparam int unsigned AW   = 11;
   localparam int unsigned DW   = 8;
   localparam int unsigned GW   = 2;
   localparam int          SIZE = 1536;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic [N-1:0]      req_ready;
   logic              clear_start = 1'b0;
   logic              clear_busy;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [GW-1:0]     grant_id;
   logic              oob_drop;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int            m_ptr;
   int            m_pos;
   bit            m_clearing;
   logic [N-1:0]  exp_ready, obs_ready;
   logic          e_wr_en, e_oob, e_busy;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   logic [GW-1:0] e_gid;

   osd_char_wr_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .grant_id    (grant_id),
      .oob_drop    (oob_drop)
   );

   always #5 clk = ~clk;

   function automatic logic [N*AW-1:0] pack_addr(input int a0, input int a1, input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [N*AW-1:0] rand_addrs(input bit allow_oob);
      logic [N*AW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (allow_oob && $urandom_range(0, 7) == 0)
            r[i*AW +: AW] = AW'($urandom_range(SIZE, 2047));
         else
            r[i*AW +: AW] = AW'($urandom_range(0, SIZE - 1));
      end
      return r;
   endfunction

   function automatic logic [N*DW-1:0] rand_data();
      return (N*DW)'($urandom);
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_pos = 0; m_clearing = 0;
      e_wr_en = 0; e_oob = 0; e_busy = 0;
      e_addr = '0; e_data = '0; e_gid = '0;
   endtask

   // One cycle of the write-port rules: expected ready now, expected outputs after the edge.
   task automatic model_step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                             input logic [N*DW-1:0] d, input logic cs);
      int w;
      int c;
      exp_ready = '0;
      e_wr_en = 0;
      e_oob = 0;
      if (m_clearing) begin
         e_wr_en = 1; e_addr = AW'(m_pos); e_data = 8'h20;
         m_pos = m_pos + 1;
         if (m_pos == SIZE) m_clearing = 0;
      end else if (cs) begin
         m_clearing = 1; m_pos = 0;
      end else begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (w < 0 && v[c]) w = c;
         end
         if (w >= 0) begin
            exp_ready[w] = 1'b1;
            m_ptr = (w + 1) % N;
            if (int'(a[w*AW +: AW]) < SIZE) begin
               e_wr_en = 1; e_addr = a[w*AW +: AW]; e_data = d[w*DW +: DW]; e_gid = GW'(w);
            end else begin
               e_oob = 1;
            end
         end
      end
      e_busy = m_clearing;
   endtask

   // Drive one cycle, sample ready mid-cycle, then step past the edge.
   task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                        input logic [N*DW-1:0] d, input logic cs);
      req_valid = v; req_addr = a; req_data = d; clear_start = cs;
      #2;
      obs_ready = req_ready;
      model_step(v, a, d, cs);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req_valid = '0; clear_start = 0;
      reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic test_reset();
      req_valid = 3'b111; req_addr = pack_addr(1, 2, 3); req_data = '1; clear_start = 0;
      model_reset();
      reset = 1;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, grant_id, oob_drop, clear_busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%0h want=0", {wr_en, wr_addr, wr_data, grant_id, oob_drop, clear_busy});
      end
      checks++;
      if (req_ready !== 3'b000) begin
         failures++;
         $display("FAIL reset_ready got=%b want=000", req_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      req_valid = '0;
      @(posedge clk);
      #1;
      checks++;
      if ({wr_en, oob_drop, clear_busy} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle got=%b want=000", {wr_en, oob_drop, clear_busy});
      end
   endtask

   task automatic test_single();
      logic [N*DW-1:0] d;
      apply_reset();
      d = '0;
      d[DW +: DW] = 8'h2D;
      cycle(3'b010, pack_addr(0, 298, 0), d, 0);
      checks++;
      if (obs_ready !== 3'b010) begin
         failures++;
         $display("FAIL single_ready got=%b want=010", obs_ready);
      end
      checks++;
      if ({wr_en, wr_addr, wr_data, grant_id} !== {1'b1, 11'd298, 8'h2D, 2'd1}) begin
         failures++;
         $display("FAIL single_write got en=%b a=%0d d=%h g=%0d want en=1 a=298 d=2d g=1",
                  wr_en, wr_addr, wr_data, grant_id);
      end
      cycle(3'b000, pack_addr(0, 298, 0), d, 0);
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 11'd298 || grant_id !== 2'd1) begin
         failures++;
         $display("FAIL single_hold got en=%b a=%0d g=%0d want en=0 a=298 g=1", wr_en, wr_addr, grant_id);
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(3'b111, rand_addrs(0), rand_data(), 0);
         checks++;
         if (obs_ready !== (3'b001 << (i % 3))) begin
            failures++;
            $display("FAIL fair_ready[%0d] got=%b want=%b", i, obs_ready, 3'b001 << (i % 3));
         end
         checks++;
         if (wr_en !== 1'b1 || grant_id !== GW'(i % 3) || wr_addr !== e_addr || wr_data !== e_data) begin
            failures++;
            $display("FAIL fair_write[%0d] got en=%b g=%0d a=%0d d=%h want en=1 g=%0d a=%0d d=%h",
                     i, wr_en, grant_id, wr_addr, wr_data, i % 3, e_addr, e_data);
         end
      end
   endtask

   task automatic test_oob();
      apply_reset();
      cycle(3'b001, pack_addr(1536, 5, 6), rand_data(), 0);
      checks++;
      if (obs_ready !== 3'b001) begin
         failures++;
         $display("FAIL oob_ready got=%b want=001", obs_ready);
      end
      checks++;
      if (wr_en !== 1'b0 || oob_drop !== 1'b1) begin
         failures++;
         $display("FAIL oob_drop got en=%b oob=%b want en=0 oob=1", wr_en, oob_drop);
      end
      cycle(3'b011, pack_addr(7, 9, 6), rand_data(), 0);
      checks++;
      if (obs_ready !== 3'b010 || wr_en !== 1'b1 || grant_id !== 2'd1 || oob_drop !== 1'b0) begin
         failures++;
         $display("FAIL oob_next got rdy=%b en=%b g=%0d oob=%b want rdy=010 en=1 g=1 oob=0",
                  obs_ready, wr_en, grant_id, oob_drop);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         cycle(N'($urandom_range(0, 7)), rand_addrs(1), rand_data(), 0);
         checks++;
         if (obs_ready !== exp_ready) begin
            failures++;
            $display("FAIL rnd_ready[%0d] got=%b want=%b", i, obs_ready, exp_ready);
         end
         checks++;
         if (wr_en !== e_wr_en || oob_drop !== e_oob) begin
            failures++;
            $display("FAIL rnd_ctl[%0d] got en=%b oob=%b want en=%b oob=%b", i, wr_en, oob_drop, e_wr_en, e_oob);
         end
         if (e_wr_en) begin
            checks++;
            if (wr_addr !== e_addr || wr_data !== e_data || grant_id !== e_gid) begin
               failures++;
               $display("FAIL rnd_write[%0d] got a=%0d d=%h g=%0d want a=%0d d=%h g=%0d",
                        i, wr_addr, wr_data, grant_id, e_addr, e_data, e_gid);
            end
         end
      end
   endtask

   // Clear launched against all-valid requesters; optional second pulse at addr 100.
   task automatic test_clear(input bit repulse);
      int saved_ptr;
      int nwr;
      int ncyc;
      bit bad_order;
      for (int i = 0; i < 2 + int'($urandom_range(0, 2)); i++) cycle(3'b111, rand_addrs(0), rand_data(), 0);
      saved_ptr = m_ptr;
      cycle(3'b111, rand_addrs(0), rand_data(), 1);
      checks++;
      if (obs_ready !== 3'b000 || clear_busy !== 1'b1 || wr_en !== 1'b0) begin
         failures++;
         $display("FAIL clr_start got rdy=%b busy=%b en=%b want rdy=000 busy=1 en=0", obs_ready, clear_busy, wr_en);
      end
      nwr = 0; ncyc = 0; bad_order = 0;
      while (e_busy && ncyc < 1700) begin
         cycle(3'b111, rand_addrs(0), rand_data(), repulse && m_pos == 100);
         ncyc++;
         if (obs_ready !== 3'b000 || clear_busy !== e_busy) begin
            bad_order = 1;
            $display("info clear ctl at cycle %0d rdy=%b busy=%b", ncyc, obs_ready, clear_busy);
         end
         if (wr_en === 1'b1) begin
            if (wr_addr !== AW'(nwr) || wr_data !== 8'h20) bad_order = 1;
            nwr++;
         end
      end
      checks++;
      if (ncyc >= 1700) begin
         failures++;
         $display("FAIL clr_timeout cycles=%0d limit=1700", ncyc);
      end
      checks++;
      if (bad_order) begin
         failures++;
         $display("FAIL clr_sequence got out-of-order or wrong data want addrs 0..1535 of 20");
      end
      checks++;
      if (nwr !== SIZE || ncyc !== SIZE) begin
         failures++;
         $display("FAIL clr_length got writes=%0d cycles=%0d want %0d", nwr, ncyc, SIZE);
      end
      checks++;
      if (clear_busy !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 11'd1535) begin
         failures++;
         $display("FAIL clr_last got busy=%b en=%b a=%0d want busy=0 en=1 a=1535", clear_busy, wr_en, wr_addr);
      end
      cycle(3'b111, rand_addrs(0), rand_data(), 0);
      checks++;
      if (obs_ready !== (3'b001 << saved_ptr) || grant_id !== GW'(saved_ptr)) begin
         failures++;
         $display("FAIL clr_resume got rdy=%b g=%0d want rdy=%b g=%0d",
                  obs_ready, grant_id, 3'b001 << saved_ptr, saved_ptr);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      apply_reset();
      cycle(3'b000, '0, '0, 1);
      n = 0;
      while (!(e_wr_en && e_addr == 11'd700) && n < 800) begin
         cycle(3'b111, rand_addrs(0), rand_data(), 0);
         n++;
      end
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 11'd700) begin
         failures++;
         $display("FAIL mid_reach got en=%b a=%0d want en=1 a=700", wr_en, wr_addr);
      end
      reset = 1;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, grant_id, oob_drop, clear_busy, req_ready} !== '0) begin
         failures++;
         $display("FAIL mid_async got=%0h want=0",
                  {wr_en, wr_addr, wr_data, grant_id, oob_drop, clear_busy, req_ready});
      end
      model_reset();
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      cycle(3'b000, '0, '0, 0);
      checks++;
      if (clear_busy !== 1'b0 || wr_en !== 1'b0) begin
         failures++;
         $display("FAIL mid_idle got busy=%b en=%b want busy=0 en=0", clear_busy, wr_en);
      end
      cycle(3'b000, '0, '0, 1);
      cycle(3'b000, '0, '0, 0);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 8'h20 || clear_busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_restart got en=%b a=%0d d=%h busy=%b want en=1 a=0 d=20 busy=1",
                  wr_en, wr_addr, wr_data, clear_busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_oob();
      test_random();
      test_clear(0);
      test_clear(1);
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
